// File: rtl/lcd_power_seq_if.sv
// Signal bundle between the display enable logic and lcd_power_seq.
// Macro LCD_BL_PWM_EN adds the backlight duty input.
interface lcd_power_seq_if;
  logic       en_i;
  logic       vsync_i;
  logic       panel_pwr_o;
  logic       timing_run_o;
  logic       data_en_o;
  logic       bl_en_o;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;
`ifdef LCD_BL_PWM_EN
  logic [7:0] bl_duty_i;

  modport master (
    output en_i, vsync_i, bl_duty_i,
    input  panel_pwr_o, timing_run_o, data_en_o, bl_en_o,
    input  ready_o, fault_o, state_o
  );

  modport slave (
    input  en_i, vsync_i, bl_duty_i,
    output panel_pwr_o, timing_run_o, data_en_o, bl_en_o,
    output ready_o, fault_o, state_o
  );
`else
  modport master (
    output en_i, vsync_i,
    input  panel_pwr_o, timing_run_o, data_en_o, bl_en_o,
    input  ready_o, fault_o, state_o
  );

  modport slave (
    input  en_i, vsync_i,
    output panel_pwr_o, timing_run_o, data_en_o, bl_en_o,
    output ready_o, fault_o, state_o
  );
`endif
endinterface

// File: rtl/lcd_power_seq.sv
// LCD panel power / timing / data / backlight sequencer.
// Counts frames from the active-low VSYNC of the timing generator.
// Macro LCD_BL_PWM_EN: backlight is PWM-gated by bus.bl_duty_i.
module lcd_power_seq #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned PWR_DLY       = 270000,
  parameter int unsigned SETTLE_FRAMES = 4,
  parameter int unsigned BL_DLY        = 270000,
  parameter int unsigned OFF_FRAMES    = 2,
  parameter int unsigned VS_TIMEOUT    = 1048575
) (
  input logic CLK,
  input logic RST,
  lcd_power_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_UP   = 3'd1,
    S_RUN_WAIT = 3'd2,
    S_BL_DLY   = 3'd3,
    S_ON       = 3'd4,
    S_BL_OFF   = 3'd5,
    S_PWR_DN   = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BL_LAST     = CNT_W'(BL_DLY - 1);
  localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(OFF_FRAMES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(VS_TIMEOUT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] to;
  logic             vs_q;
  logic             frame_edge;
  logic             cnt_step;
  logic             to_active;

  assign frame_edge = vs_q & ~bus.vsync_i;
  assign to_active  = (state == S_RUN_WAIT) || (state == S_BL_OFF);

  // State register and VSYNC edge history
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_OFF;
      vs_q  <= 1'b1;
    end else begin
      state <= state_nx;
      vs_q  <= bus.vsync_i;
    end
  end

  // Shared delay/frame counter and VSYNC watchdog, both restart on every state change
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      to  <= '0;
    end else begin
      if (state_nx != state)
        cnt <= '0;
      else if (cnt_step)
        cnt <= cnt + CNT_W'(1);

      if ((state_nx != state) || frame_edge || !to_active)
        to <= '0;
      else if (to != '1)
        to <= to + CNT_W'(1);
    end
  end

  // Next-state selection; en_i drop has priority wherever it is honoured
  always_comb begin
    state_nx = state;
    cnt_step = 1'b0;
    case (state)
      S_OFF: begin
        if (bus.en_i) state_nx = S_PWR_UP;
      end
      S_PWR_UP: begin
        cnt_step = 1'b1;
        if (!bus.en_i)             state_nx = S_PWR_DN;
        else if (cnt == PWR_LAST)  state_nx = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        cnt_step = frame_edge;
        if (!bus.en_i)                              state_nx = S_BL_OFF;
        else if (to == TO_LAST)                     state_nx = S_FAULT;
        else if (frame_edge && cnt == SETTLE_LAST)  state_nx = S_BL_DLY;
      end
      S_BL_DLY: begin
        cnt_step = 1'b1;
        if (!bus.en_i)            state_nx = S_BL_OFF;
        else if (cnt == BL_LAST)  state_nx = S_ON;
      end
      S_ON: begin
        if (!bus.en_i) state_nx = S_BL_OFF;
      end
      S_BL_OFF: begin
        cnt_step = frame_edge;
        if ((frame_edge && cnt == OFF_LAST) || (to == TO_LAST))
          state_nx = S_PWR_DN;
      end
      S_PWR_DN: begin
        cnt_step = 1'b1;
        if (cnt == PWR_LAST) state_nx = S_OFF;
      end
      S_FAULT: begin
        if (!bus.en_i) state_nx = S_OFF;
      end
      default: state_nx = S_OFF;
    endcase
  end

`ifdef LCD_BL_PWM_EN
  logic [7:0] pwm_cnt;
  logic       bl_pwm_q;

  // Free-running PWM period counter and registered backlight gate
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt  <= '0;
      bl_pwm_q <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 8'd1;
      bl_pwm_q <= (state == S_ON) && (pwm_cnt < bus.bl_duty_i);
    end
  end
`endif

  // Output decode of the registered state
  always_comb begin
    bus.panel_pwr_o  = 1'b0;
    bus.timing_run_o = 1'b0;
    bus.data_en_o    = 1'b0;
    bus.bl_en_o      = 1'b0;
    bus.ready_o      = 1'b0;
    bus.fault_o      = 1'b0;
    bus.state_o      = state;
    case (state)
      S_PWR_UP, S_PWR_DN: begin
        bus.panel_pwr_o = 1'b1;
      end
      S_RUN_WAIT, S_BL_OFF: begin
        bus.panel_pwr_o  = 1'b1;
        bus.timing_run_o = 1'b1;
      end
      S_BL_DLY: begin
        bus.panel_pwr_o  = 1'b1;
        bus.timing_run_o = 1'b1;
        bus.data_en_o    = 1'b1;
      end
      S_ON: begin
        bus.panel_pwr_o  = 1'b1;
        bus.timing_run_o = 1'b1;
        bus.data_en_o    = 1'b1;
`ifndef LCD_BL_PWM_EN
        bus.bl_en_o      = 1'b1;
`endif
        bus.ready_o      = 1'b1;
      end
      S_FAULT: begin
        bus.fault_o = 1'b1;
      end
      default: ;
    endcase
`ifdef LCD_BL_PWM_EN
    bus.bl_en_o = bl_pwm_q;
`endif
  end

endmodule
